// File: rtl/bus_master_if_if.sv
// CPU-side access port and shared-bus master port of the bus master controller.
// The master modport is the controller's view; slave is the CPU/arbiter/bus environment.
interface bus_master_if_if;
  logic [29:0] if_addr;
  logic        if_as_;
  logic        if_rw;
  logic [31:0] if_wr_data;
  logic        flush;
  logic [31:0] if_rd_data;
  logic        busy;
  logic        err;
  logic        bus_req_;
  logic        bus_grnt_;
  logic [29:0] bus_addr;
  logic        bus_as_;
  logic        bus_rw;
  logic [31:0] bus_wr_data;
  logic [31:0] bus_rd_data;
  logic        bus_rdy_;

  modport master (
    input  if_addr, if_as_, if_rw, if_wr_data, flush,
    input  bus_grnt_, bus_rd_data, bus_rdy_,
    output if_rd_data, busy, err,
    output bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data
  );

  modport slave (
    output if_addr, if_as_, if_rw, if_wr_data, flush,
    output bus_grnt_, bus_rd_data, bus_rdy_,
    input  if_rd_data, busy, err,
    input  bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data
  );
endinterface

// File: rtl/bus_master_if.sv
// Bus master controller: turns one CPU access into request/grant/strobe/ready
// bus cycles, stalls the CPU through busy and aborts hung slaves after TIMEOUT.
//
// state  | meaning
// IDLE   | no access; latches a new CPU request into the bus registers
// REQ    | bus_req_ low, waiting for grant (flush may cancel)
// ACCESS | single cycle with bus_as_ low; first bus_rdy_ sample
// WAIT   | waiting for bus_rdy_, timeout counter running
// DONE   | one cycle result hand-back; CPU strobe ignored, err valid
module bus_master_if #(
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  bus_master_if_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ACCESS,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam logic [7:0] TC = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic        r_req_n;
  logic        r_as_n;
  logic        r_rw;
  logic [29:0] r_addr;
  logic [31:0] r_wr_data;
  logic [31:0] r_rd_data;
  logic        r_err;
  logic [7:0]  r_cnt;

  state_t      w_state_nxt;
  logic        w_req_n;
  logic        w_as_n;
  logic        w_rw;
  logic [29:0] w_addr;
  logic [31:0] w_wr_data;
  logic [31:0] w_rd_data;
  logic        w_err;
  logic [7:0]  w_cnt;
  logic        w_busy;
  logic        w_complete;
  logic        w_abort;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_req_n   <= 1'b1;
      r_as_n    <= 1'b1;
      r_rw      <= 1'b1;
      r_addr    <= '0;
      r_wr_data <= '0;
      r_rd_data <= '0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_req_n   <= w_req_n;
      r_as_n    <= w_as_n;
      r_rw      <= w_rw;
      r_addr    <= w_addr;
      r_wr_data <= w_wr_data;
      r_rd_data <= w_rd_data;
      r_err     <= w_err;
      r_cnt     <= w_cnt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_n     = r_req_n;
    w_as_n      = 1'b1;
    w_rw        = r_rw;
    w_addr      = r_addr;
    w_wr_data   = r_wr_data;
    w_rd_data   = r_rd_data;
    w_err       = 1'b0;
    w_cnt       = r_cnt;
    w_busy      = 1'b0;
    w_complete  = 1'b0;
    w_abort     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (!bus.if_as_ && !bus.flush) begin
          w_busy      = 1'b1;
          w_addr      = bus.if_addr;
          w_rw        = bus.if_rw;
          w_wr_data   = bus.if_wr_data;
          w_req_n     = 1'b0;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        w_busy = 1'b1;
        // Cancel wins over a grant arriving in the same cycle.
        if (bus.flush) begin
          w_req_n     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (!bus.bus_grnt_) begin
          w_as_n      = 1'b0;
          w_cnt       = '0;
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        w_busy = 1'b1;
        if (!bus.bus_rdy_) begin
          w_complete = 1'b1;
        end else begin
          w_cnt       = 8'd1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_busy = 1'b1;
        if (!bus.bus_rdy_) begin
          w_complete = 1'b1;
        end else if (r_cnt == TC) begin
          w_abort = 1'b1;
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_req_n     = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_complete) begin
      w_req_n     = 1'b1;
      w_state_nxt = ST_DONE;
      if (r_rw) begin
        w_rd_data = bus.bus_rd_data;
      end
    end

    if (w_abort) begin
      w_req_n     = 1'b1;
      w_rd_data   = '0;
      w_err       = 1'b1;
      w_state_nxt = ST_DONE;
    end
  end

  assign bus.bus_req_    = r_req_n;
  assign bus.bus_as_     = r_as_n;
  assign bus.bus_rw      = r_rw;
  assign bus.bus_addr    = r_addr;
  assign bus.bus_wr_data = r_wr_data;
  assign bus.if_rd_data  = r_rd_data;
  assign bus.err         = r_err;
  assign bus.busy        = w_busy;

endmodule
